// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC float front end.
// IEEE-754 single field layout, operand classes and width helpers.
package cordic_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int SHIFT_W  = 10;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    NORMAL,
    ZERO,
    INF,
    NAN
  } fp_class_e;

  function automatic int fixed_width(int int_bits, int frac_bits);
    return int_bits + frac_bits + 1;
  endfunction

  // Subnormals land in ZERO: they are flushed.
  function automatic fp_class_e classify(fp32_t f);
    fp_class_e c;
    c = NORMAL;
    unique case (1'b1)
      (f.exp == '0):                  c = ZERO;
      (f.exp == '1 && f.mant != '0):  c = NAN;
      (f.exp == '1 && f.mant == '0):  c = INF;
      default:                        c = NORMAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/barrel_shift_gs.sv
// Bidirectional shifter of an integer mantissa into a magnitude,
// with guard, sticky and overflow detection.
module barrel_shift_gs #(
  parameter int MW = 24,
  parameter int OW = 25,
  parameter int SW = 10
) (
  input  logic [MW-1:0]        mant,
  input  logic signed [SW-1:0] shift,
  output logic [OW-1:0]        mag,
  output logic                 guard,
  output logic                 sticky,
  output logic                 overflow
);

  localparam int LW   = MW + OW;
  localparam int RW   = 2 * MW + 2;
  localparam int RMAX = MW + 1;

  logic [LW-1:0] lframe;
  logic [RW-1:0] rframe;
  logic [LW-1:0] ipart;
  logic [SW-1:0] lamt;
  logic [SW-1:0] ramt;
  logic          far;

  always_comb begin
    lframe = '0;
    rframe = '0;
    ipart  = '0;
    lamt   = shift;
    ramt   = -shift;
    far    = 1'b0;
    guard  = 1'b0;
    sticky = 1'b0;
    if (!shift[SW-1]) begin
      if (lamt > SW'(OW)) begin
        far = |mant;
      end else begin
        lframe = {{OW{1'b0}}, mant} << lamt;
        ipart  = lframe;
      end
    end else begin
      // Beyond MW+1 the whole mantissa sits below the guard position.
      if (ramt > SW'(RMAX)) begin
        sticky = |mant;
      end else begin
        rframe = {mant, {(MW+2){1'b0}}} >> ramt;
        ipart  = LW'(rframe[RW-1:MW+2]);
        guard  = rframe[MW+1];
        sticky = |rframe[MW:0];
      end
    end
    mag      = ipart[OW-1:0];
    overflow = far | (|ipart[LW-1:OW]);
  end

endmodule

// File: rtl/fp_to_fixed_pipe.sv
// Three-stage IEEE-754 single to signed Q(INT.FRAC) converter
// with rounding, saturation and valid/ready flow control.
module fp_to_fixed_pipe
  import cordic_pkg::*;
#(
  parameter  int FRACTIONAL_BITS = 22,
  parameter  int INT_BITS        = 1,
  parameter  int ROUND_NEAREST   = 1,
  localparam int W = fixed_width(INT_BITS, FRACTIONAL_BITS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         out_inv
);

  localparam int MW   = MANT_W + 1;
  localparam int OW   = W + 1;
  localparam int SOFS = EXP_BIAS + MANT_W - FRACTIONAL_BITS;

  localparam logic [OW:0] POS_MAX =
    {2'b00, 1'b0, {(W-1){1'b1}}};
  localparam logic [OW:0] NEG_MAX =
    {2'b00, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  logic ld1, ld2, ld3;

  logic                      v1;
  fp_class_e                 cls1;
  logic                      sign1;
  logic [MW-1:0]             mant1;
  logic signed [SHIFT_W-1:0] shift1;

  logic          v2;
  fp_class_e     cls2;
  logic          sign2;
  logic [OW-1:0] mag2;
  logic          g2, t2, sovf2;

  fp32_t                     f;
  fp_class_e                 cls_in;
  logic signed [SHIFT_W-1:0] shift_in;

  logic [OW-1:0] sh_mag;
  logic          sh_g, sh_t, sh_ovf;

  logic          inc;
  logic [OW:0]   rmag;
  logic [W-1:0]  res;
  logic          rovf, rinv;

  assign ld3      = !out_valid || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  always_comb begin
    f        = in_data;
    cls_in   = classify(f);
    shift_in = $signed({{(SHIFT_W-EXP_W){1'b0}}, f.exp})
             - $signed(SHIFT_W'(SOFS));
  end

  barrel_shift_gs #(
    .MW(MW),
    .OW(OW),
    .SW(SHIFT_W)
  ) u_shift (
    .mant    (mant1),
    .shift   (shift1),
    .mag     (sh_mag),
    .guard   (sh_g),
    .sticky  (sh_t),
    .overflow(sh_ovf)
  );

  always_comb begin
    inc  = (ROUND_NEAREST != 0) && g2 && (t2 || mag2[0]);
    rmag = {1'b0, mag2} + {{OW{1'b0}}, inc};
    res  = '0;
    rovf = 1'b0;
    rinv = 1'b0;
    unique case (cls2)
      ZERO: res = '0;
      NAN:  rinv = 1'b1;
      INF: begin
        res  = sign2 ? SAT_NEG : SAT_POS;
        rovf = 1'b1;
      end
      NORMAL: begin
        // -2^(W-1) is representable, so the negative limit is one larger.
        if (sovf2 || (!sign2 && rmag > POS_MAX)
                  || (sign2 && rmag > NEG_MAX)) begin
          res  = sign2 ? SAT_NEG : SAT_POS;
          rovf = 1'b1;
        end else begin
          res = sign2 ? W'(0) - rmag[W-1:0] : rmag[W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_inv   <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) begin
        out_valid <= v2;
        if (v2) begin
          out_data <= res;
          out_ovf  <= rovf;
          out_inv  <= rinv;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      cls1   <= cls_in;
      sign1  <= f.sign;
      mant1  <= {1'b1, f.mant};
      shift1 <= shift_in;
    end
    if (ld2 && v1) begin
      cls2  <= cls1;
      sign2 <= sign1;
      mag2  <= sh_mag;
      g2    <= sh_g;
      t2    <= sh_t;
      sovf2 <= sh_ovf;
    end
  end

endmodule
